// File: rtl/sprinkler_pkg.sv
// Shared types and helpers for the LFSR pixel sprinkler.
package sprinkler_pkg;

  localparam int unsigned MAX_HALF = 8;
  localparam int unsigned IDX_W    = 2 * MAX_HALF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SEED,
    ST_WAIT,
    ST_STEP,
    ST_CHECK,
    ST_LAST,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [MAX_HALF-1:0] row;
    logic [MAX_HALF-1:0] col;
  } pixel_addr_t;

  // Split an LFSR index into row (upper half) and column (lower half).
  function automatic pixel_addr_t pixel_of(input logic [IDX_W-1:0] idx,
                                           input int unsigned num_bits);
    pixel_addr_t     p;
    int unsigned     half;
    logic [IDX_W-1:0] mask;
    half  = num_bits / 2;
    mask  = (IDX_W'(1) << half) - IDX_W'(1);
    p.row = MAX_HALF'((idx >> half) & mask);
    p.col = MAX_HALF'(idx & mask);
    return p;
  endfunction

endpackage

// File: rtl/fb_shadow.sv
// Shadow copy of the square framebuffer: row read, per-bit update, row init.
module fb_shadow #(
  parameter int unsigned R_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_en,
  input  logic [R_BITS-1:0]          init_row,
  input  logic                       init_val,
  input  logic                       bit_en,
  input  logic [R_BITS-1:0]          bit_row,
  input  logic [R_BITS-1:0]          bit_col,
  input  logic                       bit_val,
  input  logic [R_BITS-1:0]          rd_row,
  output logic [(2**R_BITS)-1:0]     rd_data_c
);

  localparam int unsigned R = 2 ** R_BITS;

  logic [R-1:0][R-1:0] mem;

  // Row initialise has priority over single-pixel updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (init_en) begin
      mem[init_row] <= {R{init_val}};
    end else if (bit_en) begin
      mem[bit_row][bit_col] <= bit_val;
    end
  end

  assign rd_data_c = mem[rd_row];

endmodule

// File: rtl/lfsr_pixel_sprinkler.sv
// Dissolve effect: seeds and paces an external LFSR, maps each value to one
// framebuffer pixel and issues full-row writes from a shadow copy.
// Optional macro SPRINKLER_FREE_SEED_EN: seed taken from a free-running counter.
module lfsr_pixel_sprinkler
  import sprinkler_pkg::*;
#(
  parameter int unsigned         NUM_BITS = 6,
  parameter int unsigned         TICK_DIV = 4,
  parameter logic [NUM_BITS-1:0] SEED     = NUM_BITS'(1)
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst_L,
  input  logic                            i_Start,
  input  logic                            i_Clear,
  input  logic [NUM_BITS-1:0]             i_LFSR_Data,
  input  logic                            i_LFSR_Done,
  output logic                            o_LFSR_Enable,
  output logic                            o_Seed_DV,
  output logic [NUM_BITS-1:0]             o_Seed_Data,
  output logic                            o_Wr_En,
  output logic [(NUM_BITS/2)-1:0]         o_Wr_Row,
  output logic [(2**(NUM_BITS/2))-1:0]    o_Wr_Data,
  output logic                            o_Busy,
  output logic                            o_Done,
  output logic                            o_Err
);

  localparam int unsigned HALF   = NUM_BITS / 2;
  localparam int unsigned R      = 2 ** HALF;
  localparam int unsigned STEPS  = (2 ** NUM_BITS) - 1;
  localparam int unsigned TICK_W = $clog2(TICK_DIV + 1);

  state_t              state, state_nxt;
  logic [HALF-1:0]     row_cnt, row_cnt_nxt;
  logic [NUM_BITS-1:0] step_cnt, step_cnt_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
  logic                clear_mode, clear_mode_nxt;

  logic                wr_en, wr_en_nxt;
  logic [HALF-1:0]     wr_row, wr_row_nxt;
  logic [R-1:0]        wr_data, wr_data_nxt;
  logic                lfsr_en, lfsr_en_nxt;
  logic                seed_dv, seed_dv_nxt;
  logic [NUM_BITS-1:0] seed_data, seed_data_nxt;
  logic                busy, busy_nxt;
  logic                done, done_nxt;
  logic                err, err_nxt;

  logic                init_en_c, bit_en_c;
  logic [HALF-1:0]     tgt_row_c, tgt_col_c;
  logic [R-1:0]        row_rd_c, new_row_c;
  logic [NUM_BITS-1:0] free_seed_c;
  pixel_addr_t         pix;
  logic                unused_pix;

  assign pix        = pixel_of(IDX_W'(i_LFSR_Data), NUM_BITS);
  assign unused_pix = ^pix;

`ifdef SPRINKLER_FREE_SEED_EN
  logic [NUM_BITS-1:0] free_cnt;

  // Free-running seed source; all-ones is the LFSR lock-up value, so avoid it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) free_cnt <= NUM_BITS'(1);
    else          free_cnt <= free_cnt + NUM_BITS'(1);
  end

  assign free_seed_c = (&free_cnt) ? SEED : free_cnt;
`else
  assign free_seed_c = SEED;
`endif

  fb_shadow #(
    .R_BITS (HALF)
  ) u_shadow (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .init_en   (init_en_c),
    .init_row  (row_cnt),
    .init_val  (clear_mode),
    .bit_en    (bit_en_c),
    .bit_row   (tgt_row_c),
    .bit_col   (tgt_col_c),
    .bit_val   (~clear_mode),
    .rd_row    (tgt_row_c),
    .rd_data_c (row_rd_c)
  );

  // Target pixel: captured LFSR value, or the all-ones pixel in LAST.
  always_comb begin
    tgt_row_c = HALF'(pix.row);
    tgt_col_c = HALF'(pix.col);
    if (state == ST_LAST) begin
      tgt_row_c = '1;
      tgt_col_c = '1;
    end
    if (clear_mode) new_row_c = row_rd_c & ~(R'(1) << tgt_col_c);
    else            new_row_c = row_rd_c |  (R'(1) << tgt_col_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    row_cnt_nxt    = row_cnt;
    step_cnt_nxt   = step_cnt;
    tick_cnt_nxt   = tick_cnt;
    clear_mode_nxt = clear_mode;
    wr_en_nxt      = 1'b0;
    wr_row_nxt     = wr_row;
    wr_data_nxt    = wr_data;
    lfsr_en_nxt    = 1'b0;
    seed_dv_nxt    = 1'b0;
    seed_data_nxt  = seed_data;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    err_nxt        = err;
    init_en_c      = 1'b0;
    bit_en_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          clear_mode_nxt = i_Clear;
          err_nxt        = 1'b0;
          busy_nxt       = 1'b1;
          row_cnt_nxt    = '0;
          seed_data_nxt  = free_seed_c;
          state_nxt      = ST_INIT;
        end
      end
      ST_INIT: begin
        wr_en_nxt   = 1'b1;
        wr_row_nxt  = row_cnt;
        wr_data_nxt = clear_mode ? '1 : '0;
        init_en_c   = 1'b1;
        row_cnt_nxt = row_cnt + HALF'(1);
        if (row_cnt == HALF'(R - 1)) state_nxt = ST_SEED;
      end
      ST_SEED: begin
        seed_dv_nxt  = 1'b1;
        step_cnt_nxt = '0;
        tick_cnt_nxt = TICK_W'(TICK_DIV - 1);
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick_cnt == '0) state_nxt = ST_STEP;
        else                tick_cnt_nxt = tick_cnt - TICK_W'(1);
      end
      ST_STEP: begin
        wr_en_nxt    = 1'b1;
        wr_row_nxt   = tgt_row_c;
        wr_data_nxt  = new_row_c;
        lfsr_en_nxt  = 1'b1;
        bit_en_c     = 1'b1;
        step_cnt_nxt = step_cnt + NUM_BITS'(1);
        tick_cnt_nxt = TICK_W'(TICK_DIV - 1);
        // Only the first step legitimately sees the LFSR sitting on its seed.
        if (i_LFSR_Done && (step_cnt != '0)) err_nxt = 1'b1;
        if (step_cnt == NUM_BITS'(STEPS - 1)) begin
          // Two cycles: final enable goes out, then the LFSR value settles.
          tick_cnt_nxt = TICK_W'(1);
          state_nxt    = ST_CHECK;
        end else begin
          state_nxt    = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (tick_cnt != '0) begin
          tick_cnt_nxt = tick_cnt - TICK_W'(1);
        end else begin
          if (!i_LFSR_Done) err_nxt = 1'b1;
          state_nxt = ST_LAST;
        end
      end
      ST_LAST: begin
        wr_en_nxt   = 1'b1;
        wr_row_nxt  = tgt_row_c;
        wr_data_nxt = new_row_c;
        bit_en_c    = 1'b1;
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      step_cnt   <= '0;
      tick_cnt   <= '0;
      clear_mode <= 1'b0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_data    <= '0;
      lfsr_en    <= 1'b0;
      seed_dv    <= 1'b0;
      seed_data  <= SEED;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      row_cnt    <= row_cnt_nxt;
      step_cnt   <= step_cnt_nxt;
      tick_cnt   <= tick_cnt_nxt;
      clear_mode <= clear_mode_nxt;
      wr_en      <= wr_en_nxt;
      wr_row     <= wr_row_nxt;
      wr_data    <= wr_data_nxt;
      lfsr_en    <= lfsr_en_nxt;
      seed_dv    <= seed_dv_nxt;
      seed_data  <= seed_data_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  assign o_LFSR_Enable = lfsr_en;
  assign o_Seed_DV     = seed_dv;
  assign o_Seed_Data   = seed_data;
  assign o_Wr_En       = wr_en;
  assign o_Wr_Row      = wr_row;
  assign o_Wr_Data     = wr_data;
  assign o_Busy        = busy;
  assign o_Done        = done;
  assign o_Err         = err;

endmodule

// File: tb/tb_lfsr_pixel_sprinkler.sv
// Bench for lfsr_pixel_sprinkler: NUM_BITS=4 with TICK_DIV=1 and TICK_DIV=4.
module tb_lfsr_pixel_sprinkler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Hand-derived XNOR LFSR (taps 4,3) order from seed 1.
  logic [3:0] seq [15] = '{4'd1, 4'd3, 4'd7, 4'd14, 4'd13, 4'd11, 4'd6, 4'd12,
                           4'd9, 4'd2, 4'd5, 4'd10, 4'd4, 4'd8, 4'd0};

  // ---------------- DUT A: TICK_DIV=1 ----------------
  logic       start_a = 1'b0, clear_a = 1'b0;
  logic [3:0] lfsr_a;
  logic       lfsr_done_a, lfsr_en_a, seed_dv_a, wr_en_a, busy_a, done_a, err_a;
  logic [3:0] seed_data_a, wr_data_a;
  logic [1:0] wr_row_a;
  logic       arm_early = 1'b0;
  int         early_en  = 0;

  lfsr_pixel_sprinkler #(.NUM_BITS(4), .TICK_DIV(1), .SEED(4'd1)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start_a), .i_Clear(clear_a),
    .i_LFSR_Data(lfsr_a), .i_LFSR_Done(lfsr_done_a),
    .o_LFSR_Enable(lfsr_en_a), .o_Seed_DV(seed_dv_a), .o_Seed_Data(seed_data_a),
    .o_Wr_En(wr_en_a), .o_Wr_Row(wr_row_a), .o_Wr_Data(wr_data_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_Err(err_a));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lfsr_a <= 4'd0;
    else if (seed_dv_a)  lfsr_a <= seed_data_a;
    else if (lfsr_en_a)  lfsr_a <= {lfsr_a[2:0], ~(lfsr_a[3] ^ lfsr_a[2])};
  end

  // Stub behaviour: force Done high once 7 enables have gone out.
  always @(negedge clk) begin
    if (!arm_early)     early_en = 0;
    else if (lfsr_en_a) early_en++;
  end
  assign lfsr_done_a = (lfsr_a == seed_data_a) || (arm_early && (early_en >= 7));

  // ---------------- DUT B: TICK_DIV=4 ----------------
  logic       start_b = 1'b0;
  logic [3:0] lfsr_b;
  logic       lfsr_done_b, lfsr_en_b, seed_dv_b, wr_en_b, busy_b, done_b, err_b;
  logic [3:0] seed_data_b, wr_data_b;
  logic [1:0] wr_row_b;

  lfsr_pixel_sprinkler #(.NUM_BITS(4), .TICK_DIV(4), .SEED(4'd1)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start_b), .i_Clear(1'b0),
    .i_LFSR_Data(lfsr_b), .i_LFSR_Done(lfsr_done_b),
    .o_LFSR_Enable(lfsr_en_b), .o_Seed_DV(seed_dv_b), .o_Seed_Data(seed_data_b),
    .o_Wr_En(wr_en_b), .o_Wr_Row(wr_row_b), .o_Wr_Data(wr_data_b),
    .o_Busy(busy_b), .o_Done(done_b), .o_Err(err_b));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lfsr_b <= 4'd0;
    else if (seed_dv_b)  lfsr_b <= seed_data_b;
    else if (lfsr_en_b)  lfsr_b <= {lfsr_b[2:0], ~(lfsr_b[3] ^ lfsr_b[2])};
  end
  assign lfsr_done_b = (lfsr_b == seed_data_b);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- Scoreboard ----------------
  typedef struct packed { logic [1:0] row; logic [3:0] data; } wr_t;
  wr_t  exp_q [$];
  int   wr_cnt_a = 0, done_cnt_a = 0;
  logic [3:0] last_data_a = 4'd0;

  // Expected row writes for one dissolve of DUT A.
  task automatic push_run(input bit clr);
    logic [3:0] sh [4];
    logic [3:0] idx;
    wr_t e;
    for (int r = 0; r < 4; r++) begin
      sh[r] = clr ? 4'hF : 4'h0;
      e.row = 2'(r); e.data = sh[r];
      exp_q.push_back(e);
    end
    for (int k = 0; k < 15; k++) begin
      idx = seq[k];
      sh[idx[3:2]][idx[1:0]] = ~clr;
      e.row = idx[3:2]; e.data = sh[idx[3:2]];
      exp_q.push_back(e);
    end
    sh[3][3] = ~clr;
    e.row = 2'd3; e.data = sh[3];
    exp_q.push_back(e);
  endtask

  // Monitor for DUT A writes.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en_a) begin
      wr_cnt_a++;
      last_data_a = wr_data_a;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr row=%0d data=%h required=no write", wr_row_a, wr_data_a);
      end else begin
        e = exp_q.pop_front();
        check("wr_row_data", int'({wr_row_a, wr_data_a}), int'({e.row, e.data}));
      end
    end
    if (done_a) done_cnt_a++;
  end

  // Monitor for DUT B pacing and seeding.
  int en_cnt_b = 0, last_en_cyc_b = 0, seed_cnt_b = 0, wr_cnt_b = 0;
  always @(negedge clk) begin
    if (lfsr_en_b) begin
      if (en_cnt_b > 0) check("en_spacing_b", cyc - last_en_cyc_b, 5);
      last_en_cyc_b = cyc;
      en_cnt_b++;
    end
    if (seed_dv_b) begin
      seed_cnt_b++;
      check("seed_data_b", int'(seed_data_b), 1);
    end
    if (wr_en_b) wr_cnt_b++;
  end

  task automatic check_quiet_a(input string tag);
    check({tag, "_wr_en"},   int'(wr_en_a),   0);
    check({tag, "_wr_row"},  int'(wr_row_a),  0);
    check({tag, "_wr_data"}, int'(wr_data_a), 0);
    check({tag, "_lfsr_en"}, int'(lfsr_en_a), 0);
    check({tag, "_seed_dv"}, int'(seed_dv_a), 0);
    check({tag, "_seed"},    int'(seed_data_a), 1);
    check({tag, "_busy"},    int'(busy_a),    0);
    check({tag, "_done"},    int'(done_a),    0);
    check({tag, "_err"},     int'(err_a),     0);
  endtask

  task automatic wait_done(input bit which_b, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (which_b ? done_b : done_a) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL done_timeout waited=%0d cycles required=o_Done pulse", limit);
    end
  endtask

  task automatic pulse_start_a(input bit clr);
    @(posedge clk); #1; start_a = 1'b1; clear_a = clr;
    @(posedge clk); #1; start_a = 1'b0; clear_a = 1'b0;
  endtask

  task automatic run_a(input bit clr, input bit exp_err);
    int w0; bit ok;
    w0 = wr_cnt_a;
    push_run(clr);
    pulse_start_a(clr);
    check("busy_after_start", int'(busy_a), 1);
    check("err_cleared_on_start", int'(err_a), 0);
    wait_done(1'b0, 200, ok);
    if (ok) begin
      check("busy_at_done", int'(busy_a), 0);
      check("err_at_done", int'(err_a), int'(exp_err));
      check("writes_per_run", wr_cnt_a - w0, 20);
      check("queue_drained", exp_q.size(), 0);
      check("final_row3", int'(last_data_a), clr ? 0 : 15);
    end
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    int w0, d0, n;

    repeat (3) @(posedge clk); #1;
    check_quiet_a("reset");
    check("reset_seed_b", int'(seed_data_b), 1);
    rst_n = 1'b1;

    // Fill, then erase.
    run_a(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    run_a(1'b1, 1'b0);
    repeat (3) @(posedge clk);

    // Early Done from the stub sets a sticky error; next start clears it.
    arm_early = 1'b1;
    run_a(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("err_sticky_after_done", int'(err_a), 1);
    arm_early = 1'b0;
    run_a(1'b0, 1'b0);

    // Asynchronous reset in the middle of STEP.
    push_run(1'b0);
    pulse_start_a(1'b0);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lfsr_en_a) n++;
      if (n == 5) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL enable_timeout seen=%0d required=5", n);
    end
    @(posedge clk); #1;
    check("busy_before_rst", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    check_quiet_a("midrst");
    exp_q.delete();
    w0 = wr_cnt_a;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    check("no_wr_after_rst", wr_cnt_a - w0, 0);
    run_a(1'b0, 1'b0);
    repeat (3) @(posedge clk);

    // Start pulses while busy are ignored.
    w0 = wr_cnt_a; d0 = done_cnt_a;
    push_run(1'b0);
    pulse_start_a(1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (6) @(posedge clk);
      pulse_start_a(1'b1);
    end
    wait_done(1'b0, 200, ok);
    repeat (20) @(posedge clk);
    check("busy_ignore_writes", wr_cnt_a - w0, 20);
    check("busy_ignore_done_cnt", done_cnt_a - d0, 1);
    check("busy_ignore_queue", exp_q.size(), 0);
    exp_q.delete();

    // TICK_DIV=4 pacing.
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    wait_done(1'b1, 400, ok);
    #1;
    check("b_seed_dv_count", seed_cnt_b, 1);
    check("b_enable_count", en_cnt_b, 15);
    check("b_write_count", wr_cnt_b, 20);
    check("b_err", int'(err_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_pixel_sprinkler.md
Name: lfsr_pixel_sprinkler

Overview:
- Downstream consumer of the `lfsr` block in the Max7219 framebuffer design.
- Seeds the LFSR, steps it at a paced rate, and maps each LFSR value to one pixel of a square framebuffer. The result is a "dissolve" effect that sets or clears every pixel exactly once in pseudo-random order.
- Issues row-wide writes to the framebuffer from an internal shadow copy.
- Sits between `lfsr` and the framebuffer write port that feeds the MAX7219 row scanner.

Parameters:
- NUM_BITS, 6, LFSR width. Must be even. Framebuffer is 2^(NUM_BITS/2) x 2^(NUM_BITS/2) pixels.
- TICK_DIV, 4, idle clocks between pixel writes (>=1). Pixel period = TICK_DIV+1 clocks.
- SEED, 1, fixed LFSR seed. Must not be all-ones.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle pulse; begins a dissolve when idle
- i_Clear  in  1  sampled with i_Start: 0 = fill (pixels set), 1 = erase (pixels cleared)
- i_LFSR_Data  in  NUM_BITS  current LFSR value
- i_LFSR_Done  in  1  LFSR has returned to its seed
- o_LFSR_Enable  out  1  one-cycle step request to LFSR
- o_Seed_DV  out  1  one-cycle seed load
- o_Seed_Data  out  NUM_BITS  seed value
- o_Wr_En  out  1  framebuffer row write strobe
- o_Wr_Row  out  NUM_BITS/2  row address
- o_Wr_Data  out  2^(NUM_BITS/2)  full row contents, bit c = column c
- o_Busy  out  1  high from accepted start until DONE
- o_Done  out  1  one-cycle pulse at completion
- o_Err  out  1  sticky; LFSR period mismatch

Behaviour:
- Reset state:
  - all outputs 0; o_Seed_Data = SEED
  - shadow framebuffer = 0, FSM = IDLE, counters = 0
  - Reset is honoured mid-operation: immediate abort, no further writes.
- All outputs are registered.
- Pixel mapping:
  - index = captured LFSR value
  - row = index[NUM_BITS-1:NUM_BITS/2], col = index[NUM_BITS/2-1:0]
- The LFSR visits the 2^NUM_BITS-1 values other than all-ones. This block writes pixel all-ones explicitly as the final pixel.
- FSM states:
  - IDLE: on i_Start, latch i_Clear, clear o_Err, go to INIT. i_Start is ignored while o_Busy.
  - INIT: one row write per cycle, rows 0..R-1 (R = 2^(NUM_BITS/2)). Data is all-zeros (fill) or all-ones (erase). Shadow is updated identically. Then go to SEED.
  - SEED: o_Seed_DV high for one cycle. Step counter = 0, tick counter = TICK_DIV-1. Go to WAIT.
  - WAIT: decrement tick counter; at 0 go to STEP.
  - STEP:
    - Capture i_LFSR_Data and compute the new row = shadow row with the target bit set (fill) or cleared (erase).
    - Next cycle: o_Wr_En=1 with row/data and o_LFSR_Enable=1; shadow updated.
    - Increment the step counter and reload the tick counter.
    - If step counter reaches 2^NUM_BITS-1, go to CHECK; else go to WAIT.
  - CHECK: one cycle after the final enable. If i_LFSR_Done=0, set o_Err. Go to LAST.
  - LAST: write pixel all-ones (row R-1, col R-1). Go to DONE.
  - DONE: o_Done pulse for one cycle, o_Busy falls the same cycle. Go to IDLE.
- An i_LFSR_Done assertion before CHECK also sets o_Err. The dissolve still completes.
- Write ordering: at most one write per cycle. Each pixel is written exactly once per dissolve. Writing a pixel that already has the target value is legal.

Optional Feature:
- Macro: SPRINKLER_FREE_SEED_EN
- Defined:
  - A free-running NUM_BITS counter, reset to 1, increments every clock.
  - Its value is latched into o_Seed_Data on the accepted i_Start. If the value is all-ones, SEED is used instead.
- Undefined: o_Seed_Data is the constant SEED.

Decomposition:
- Package `sprinkler_pkg`:
  - FSM state enum (IDLE, INIT, SEED, WAIT, STEP, CHECK, LAST, DONE)
  - function returning row/col from an index, given NUM_BITS
- One sub-module `fb_shadow`: R x R bit register with row read, masked bit set/clear, and full-row initialise. All other logic stays in the top.

Test Plan:
- NUM_BITS=4, TICK_DIV=1, i_Clear=0, driven by the real `lfsr`, start pulse:
  - expect 4 INIT writes of 4'b0000, then 15 pixel writes, then 1 pixel-15 write
  - every write has exactly one new bit set; final shadow all-ones; o_Done after the last write; o_Err=0
- Same configuration with i_Clear=1:
  - INIT writes 4'b1111, final shadow all-zeros
  - each of the 16 pixels is cleared exactly once (scoreboard)
- TICK_DIV=4: consecutive o_LFSR_Enable pulses are exactly 5 clocks apart; o_Seed_DV is high exactly once, carrying SEED=1.
- Stub LFSR driving i_LFSR_Done early at step 7 -> o_Err=1 and sticky; dissolve still finishes with 20 writes total; next i_Start clears o_Err.
- Assert i_Rst_L low in the middle of STEP -> all outputs 0 asynchronously; no write after release; new i_Start produces a full clean run.
- i_Start pulses while o_Busy -> ignored: no restart, write count unchanged, single o_Done.
